partition_scheduler: RTL and testbench

Explicit-stack controller that sequences the partition datapath to perform a complete iterative quicksort over an index range. It holds pending (lo, hi) segments on a LIFO, issues one partition job at a time, and captures each returned pivot to split the segment. It replaces recursion and the fixed LEFT/RIGHT walk in the sorting top level. The array itself stays with the partition datapath and its owner; this block carries only indices and handshakes.

---
 rtl/partition_scheduler_pkg.sv | 23 ++
 rtl/partition_scheduler_if.sv | 23 ++
 rtl/partition_scheduler_seg_stack.sv | 48 ++++
 rtl/partition_scheduler.sv | 172 +++++++++++++++++
 tb/tb_partition_scheduler.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/partition_scheduler_pkg.sv
// rtl/partition_scheduler_pkg.sv - shared types for the partition scheduler
package psched_pkg;

    localparam int PSCHED_IDX_W    = 4;
    localparam int STACK_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_ISSUE,
        S_WAIT,
        S_PUSH_R,
        S_PUSH_L,
        S_DONE
    } state_t;

    // One pending segment; field width tracks the scheduler index width.
    typedef struct packed {
        logic [PSCHED_IDX_W-1:0] lo;
        logic [PSCHED_IDX_W-1:0] hi;
    } seg_t;

endpackage

// File: rtl/partition_scheduler_if.sv
// rtl/partition_scheduler_if.sv - scheduler to partition datapath handshake
interface partition_scheduler_if
    import psched_pkg::*;
#(
    parameter int IDX_W = PSCHED_IDX_W
);
    logic             part_start;
    logic [IDX_W-1:0] part_lo;
    logic [IDX_W-1:0] part_hi;
    logic             part_valid;
    logic [IDX_W-1:0] part_pivot;
    logic             array_we;

    modport master (
        output part_start, part_lo, part_hi, array_we,
        input  part_valid, part_pivot
    );

    modport slave (
        input  part_start, part_lo, part_hi, array_we,
        output part_valid, part_pivot
    );
endinterface

// File: rtl/partition_scheduler_seg_stack.sv
// rtl/partition_scheduler_seg_stack.sv - synchronous LIFO of pending segments
module seg_stack
    import psched_pkg::*;
#(
    parameter int  DEPTH = STACK_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  seg_t          din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output seg_t          top
);

    // Shift-register stack: the top of stack always lives in mem[0].
    seg_t mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !full) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
            count <= count - CW'(1);
        end
    end

    push_pop_exclusive: assert property (@(posedge clock) disable iff (reset) !(push && pop));

endmodule

// File: rtl/partition_scheduler.sv
// rtl/partition_scheduler.sv - explicit-stack quicksort sequencer; PSCHED_STATS_EN adds job_count/max_depth
module partition_scheduler
    import psched_pkg::*;
#(
    parameter int  ARR_WIDTH   = 4,
    parameter int  IDX_W       = PSCHED_IDX_W,
    parameter int  STACK_DEPTH = STACK_DEPTH_DEF,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IDX_W-1:0]       lo_ind,
    input  logic [IDX_W-1:0]       hi_ind,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    partition_scheduler_if.master  part
`ifdef PSCHED_STATS_EN
    , output logic [7:0]           job_count
    , output logic [DW-1:0]        max_depth
`endif
);

    state_t           state;
    logic [IDX_W-1:0] cur_lo;
    logic [IDX_W-1:0] cur_hi;
    logic [IDX_W-1:0] piv;

    logic          s_push;
    logic          s_pop;
    logic          s_flush;
    logic          s_full;
    logic          s_empty;
    logic [DW-1:0] s_count;
    seg_t          s_din;
    seg_t          s_top;

    seg_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (s_push),
        .pop   (s_pop),
        .flush (s_flush),
        .din   (s_din),
        .full  (s_full),
        .empty (s_empty),
        .count (s_count),
        .top   (s_top)
    );

    // Guarded pushes only; an overflowing push is caught by the FSM instead.
    always_comb begin
        s_push = 1'b0;
        s_din  = '{lo: lo_ind, hi: hi_ind};
        case (state)
            S_IDLE:   s_push = start;
            S_PUSH_R: begin
                s_push = (piv < cur_hi) && !s_full;
                s_din  = '{lo: piv + 1'b1, hi: cur_hi};
            end
            S_PUSH_L: begin
                s_push = (piv > cur_lo) && !s_full;
                s_din  = '{lo: cur_lo, hi: piv - 1'b1};
            end
            default: ;
        endcase
    end

    assign s_pop   = (state == S_POP) && !s_empty;
    assign s_flush = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            part.part_start <= 1'b0;
            part.part_lo    <= '0;
            part.part_hi    <= '0;
            part.array_we   <= 1'b0;
            cur_lo          <= '0;
            cur_hi          <= '0;
            piv             <= '0;
`ifdef PSCHED_STATS_EN
            job_count       <= '0;
            max_depth       <= '0;
`endif
        end else begin
            done            <= 1'b0;
            part.part_start <= 1'b0;
            part.array_we   <= 1'b0;
`ifdef PSCHED_STATS_EN
            if (s_count > max_depth) max_depth <= s_count;
`endif
            case (state)
                S_IDLE: if (start) begin
                    error <= 1'b0;
                    busy  <= 1'b1;
                    state <= S_POP;
`ifdef PSCHED_STATS_EN
                    job_count <= '0;
                    max_depth <= '0;
`endif
                end
                S_POP: begin
                    if (s_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cur_lo <= s_top.lo;
                        cur_hi <= s_top.hi;
                        // Single-element or empty segments are already sorted.
                        if (s_top.lo < s_top.hi) begin
                            part.part_lo    <= s_top.lo;
                            part.part_hi    <= s_top.hi;
                            part.part_start <= 1'b1;
                            state           <= S_ISSUE;
`ifdef PSCHED_STATS_EN
                            if (job_count != 8'hFF) job_count <= job_count + 8'd1;
`endif
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: if (part.part_valid) begin
                    piv           <= part.part_pivot;
                    part.array_we <= 1'b1;
                    if (part.part_pivot < cur_lo || part.part_pivot > cur_hi) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_PUSH_R;
                    end
                end
                S_PUSH_R: begin
                    if (piv < cur_hi && s_full) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_PUSH_L;
                    end
                end
                S_PUSH_L: begin
                    if (piv > cur_lo && s_full) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_POP;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    index_in_range: assert property (@(posedge clock) disable iff (reset)
        (state == S_IDLE && start) |-> (32'(lo_ind) < ARR_WIDTH && 32'(hi_ind) < ARR_WIDTH));

    depth_in_range: assert property (@(posedge clock) disable iff (reset)
        s_count <= DW'(STACK_DEPTH));

endmodule

// File: tb/tb_partition_scheduler.sv
// tb/tb_partition_scheduler.sv - self-checking bench for partition_scheduler
module tb_partition_scheduler;

    localparam int IDX_W = 4;

    typedef struct {
        int inst;
        int lo;
        int hi;
        int mode;
        int exp_err;
        int njobs;
        int jl[4];
        int jh[4];
    } vec_t;

    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             start0 = 1'b0;
    logic             start1 = 1'b0;
    logic [IDX_W-1:0] lo_ind = '0;
    logic [IDX_W-1:0] hi_ind = '0;
    logic             busy0, done0, error0;
    logic             busy1, done1, error1;
    logic             pv = 1'b0;
    logic [IDX_W-1:0] pp = '0;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     we_cnt = 0;
    int     sel = 0;
    int     mode = 0;
    int     lat = 2;
    int     sb[$];
    vec_t   vecs[8];

    always #5 clock = ~clock;

    partition_scheduler_if #(.IDX_W(IDX_W)) pif0 ();
    partition_scheduler_if #(.IDX_W(IDX_W)) pif1 ();

    assign pif0.part_valid = pv;
    assign pif0.part_pivot = pp;
    assign pif1.part_valid = pv;
    assign pif1.part_pivot = pp;

`ifdef PSCHED_STATS_EN
    logic [7:0] jc0, jc1;
    logic [3:0] md0;
    logic [0:0] md1;
`endif

    partition_scheduler #(.ARR_WIDTH(16), .IDX_W(IDX_W), .STACK_DEPTH(8)) dut0 (
        .clock  (clock),
        .reset  (reset),
        .start  (start0),
        .lo_ind (lo_ind),
        .hi_ind (hi_ind),
        .busy   (busy0),
        .done   (done0),
        .error  (error0),
        .part   (pif0)
`ifdef PSCHED_STATS_EN
        , .job_count (jc0)
        , .max_depth (md0)
`endif
    );

    partition_scheduler #(.ARR_WIDTH(16), .IDX_W(IDX_W), .STACK_DEPTH(1)) dut1 (
        .clock  (clock),
        .reset  (reset),
        .start  (start1),
        .lo_ind (lo_ind),
        .hi_ind (hi_ind),
        .busy   (busy1),
        .done   (done1),
        .error  (error1),
        .part   (pif1)
`ifdef PSCHED_STATS_EN
        , .job_count (jc1)
        , .max_depth (md1)
`endif
    );

    wire             m_ps   = (sel == 1) ? pif1.part_start : pif0.part_start;
    wire [IDX_W-1:0] m_lo   = (sel == 1) ? pif1.part_lo    : pif0.part_lo;
    wire [IDX_W-1:0] m_hi   = (sel == 1) ? pif1.part_hi    : pif0.part_hi;
    wire             m_we   = (sel == 1) ? pif1.array_we   : pif0.array_we;
    wire             m_busy = (sel == 1) ? busy1  : busy0;
    wire             m_done = (sel == 1) ? done1  : done0;
    wire             m_err  = (sel == 1) ? error1 : error0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pivot_of(input int md, input int lo, input int hi);
        case (md)
            0:       return hi;
            1:       return lo + 1;
            2:       return lo;
            3:       return (lo + hi) / 2;
            default: return 9;
        endcase
    endfunction

    // Behavioural partition datapath: answers each job after lat cycles.
    always @(negedge clock) begin
        if (!reset && m_ps) begin
            automatic int jlo = int'(m_lo);
            automatic int jhi = int'(m_hi);
            repeat (lat) @(posedge clock);
            #1;
            pv = 1'b1;
            pp = IDX_W'(pivot_of(mode, jlo, jhi));
            @(posedge clock);
            #1;
            pv = 1'b0;
        end
    end

    // Scoreboard: every issued job must match the next expected segment.
    always @(negedge clock) begin
        if (!reset && m_ps) begin
            if (sb.size() == 0) begin
                check("unexpected_part_start", int'(m_lo) * 256 + int'(m_hi), -1);
            end else begin
                automatic int e = sb.pop_front();
                check("part_bounds", int'(m_lo) * 256 + int'(m_hi), e);
            end
        end
        if (m_we) we_cnt++;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  int'(busy0), 0);
        check({tag, "_done"},  int'(done0), 0);
        check({tag, "_error"}, int'(error0), 0);
        check({tag, "_pstart"}, int'(pif0.part_start), 0);
        check({tag, "_plo"},   int'(pif0.part_lo), 0);
        check({tag, "_phi"},   int'(pif0.part_hi), 0);
        check({tag, "_we"},    int'(pif0.array_we), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        int we_base;
        for (int j = 0; j < v.njobs; j++) sb.push_back(v.jl[j] * 256 + v.jh[j]);
        mode    = v.mode;
        sel     = v.inst;
        we_base = we_cnt;
        @(posedge clock);
        #1;
        lo_ind = IDX_W'(v.lo);
        hi_ind = IDX_W'(v.hi);
        if (v.inst == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        check({tag, "_busy_after_start"}, int'(m_busy), 1);
        got = 0;
        for (int c = 0; c < 400 && got == 0; c++) begin
            @(negedge clock);
            if (m_done) got = 1;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_error"}, int'(m_err), v.exp_err);
        check({tag, "_busy_at_done"}, int'(m_busy), 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, int'(m_done), 0);
        repeat (6) @(negedge clock);
        check({tag, "_jobs_left"}, sb.size(), 0);
        check({tag, "_array_we"}, we_cnt - we_base, v.njobs);
`ifdef PSCHED_STATS_EN
        if (v.inst == 0) check({tag, "_job_count"}, int'(jc0), v.njobs);
`endif
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[1] = '{0, 0, 3, 0, 0, 3, '{0, 0, 0, 0}, '{3, 2, 1, 0}};
        vecs[2] = '{0, 0, 7, 1, 0, 4, '{0, 2, 4, 6}, '{7, 7, 7, 7}};
        vecs[3] = '{0, 0, 3, 2, 0, 3, '{0, 1, 2, 0}, '{3, 3, 3, 0}};
        vecs[4] = '{0, 0, 7, 3, 0, 4, '{0, 0, 4, 6}, '{7, 2, 7, 7}};
        vecs[5] = '{0, 5, 2, 0, 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[6] = '{0, 0, 3, 4, 1, 1, '{0, 0, 0, 0}, '{3, 0, 0, 0}};
        vecs[7] = '{1, 0, 7, 3, 1, 1, '{0, 0, 0, 0}, '{7, 0, 0, 0}};

        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        check("reset_busy1", int'(busy1), 0);
        check("reset_done1", int'(done1), 0);
        reset = 1'b0;

        // Trivial range: done two edges after the start edge, no job issued.
        sel = 0;
        @(posedge clock);
        #1;
        lo_ind = '0;
        hi_ind = '0;
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        check("triv_busy_t1", int'(busy0), 1);
        check("triv_done_t1", int'(done0), 0);
        @(posedge clock);
        #1;
        check("triv_done_t2", int'(done0), 0);
        @(posedge clock);
        #1;
        check("triv_done_t3", int'(done0), 1);
        check("triv_busy_t3", int'(busy0), 0);
        check("triv_error_t3", int'(error0), 0);
        @(posedge clock);
        #1;
        check("triv_done_t4", int'(done0), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-WAIT with a stray result arriving just after reset.
        sel  = 0;
        mode = 0;
        lat  = 3;
        sb.push_back(3);
        @(posedge clock);
        #1;
        lo_ind = 4'd0;
        hi_ind = 4'd3;
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 50 && seen == 0; c++) begin
                @(negedge clock);
                if (m_ps) seen = 1;
            end
            check("rst_issue_seen", seen, 1);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle_outputs("rst_wait");
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check_idle_outputs($sformatf("rst_after%0d", k));
        end
        lat = 2;
        run_vec(vecs[1], "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
